// File: rtl/pipe_pkg.sv
// Shared types for the fd/de/ew pipeline sequencer and the datapath registers it drives.
package pipe_pkg;

    typedef enum logic [1:0] {
        UPD_HOLD = 2'b00,
        UPD_ADV  = 2'b01,
        UPD_CLR  = 2'b10
    } upd_t;

    typedef enum logic [1:0] {
        MODE_IDLE = 2'd0,
        MODE_LOAD = 2'd1,
        MODE_EXEC = 2'd2,
        MODE_STOP = 2'd3
    } mode_t;

    localparam int LAT_W_DEF  = 5;
    localparam int PERF_W_DEF = 32;

endpackage

// File: rtl/pipe_lat_cnt.sv
// Execute latency counter: counts up to the requested wait time and flags completion
// once the count matches and no transfer is in flight.
module pipe_lat_cnt
    import pipe_pkg::*;
#(
    parameter int LAT_W = LAT_W_DEF
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             i_en,
    input  logic [LAT_W-1:0] i_wait,
    input  logic             i_busy,
    output logic             o_done
);

    logic [LAT_W-1:0] r_lat;

    assign o_done = i_en && (r_lat == i_wait) && !i_busy;

    // Saturates at the wait time so a busy execute simply parks here until released.
    always_ff @(posedge clk) begin
        if (!rstn || !i_en) begin
            r_lat <= '0;
        end else if (o_done) begin
            r_lat <= '0;
        end else if (r_lat < i_wait) begin
            r_lat <= r_lat + LAT_W'(1);
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Run-mode sequencer and per-register update-code generator for the fd/de/ew pipeline.
// Optional performance counters are built when PIPE_CTRL_PERF_EN is defined.
module pipe_ctrl
    import pipe_pkg::*;
#(
    parameter int LAT_W  = LAT_W_DEF,
    parameter int PERF_W = PERF_W_DEF
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              aa_received,
    input  logic              aa_sent,
    input  logic              load_done,
    input  logic              d_hazard,
    input  logic [LAT_W-1:0]  e_wait_time,
    input  logic              e_busy,
    input  logic              e_redirect,
    input  logic              e_stop,
    output upd_t              fd_update,
    output upd_t              de_update,
    output upd_t              ew_update,
    output logic              e_start,
    output logic              exec_done,
    output mode_t             mode,
    output logic [PERF_W-1:0] perf_cycles,
    output logic [PERF_W-1:0] perf_stalls,
    output logic [PERF_W-1:0] perf_flush
);

    mode_t r_mode, w_mode_nxt;
    logic  r_ld_f, r_ak_f;
    logic  r_e_start;
    logic  w_exec_done;
    logic  w_in_exec;
    logic  w_ld_any, w_ak_any;

    assign w_in_exec = (r_mode == MODE_EXEC);
    assign w_ld_any  = r_ld_f | load_done;
    assign w_ak_any  = r_ak_f | aa_sent;

    pipe_lat_cnt #(.LAT_W(LAT_W)) u_lat (
        .clk    (clk),
        .rstn   (rstn),
        .i_en   (w_in_exec),
        .i_wait (e_wait_time),
        .i_busy (e_busy),
        .o_done (w_exec_done)
    );

    always_ff @(posedge clk) begin
        if (!rstn) r_mode <= MODE_IDLE;
        else       r_mode <= w_mode_nxt;
    end

    always_comb begin
        w_mode_nxt = r_mode;
        case (r_mode)
            MODE_IDLE: if (aa_received)            w_mode_nxt = MODE_LOAD;
            MODE_LOAD: if (w_ld_any && w_ak_any)   w_mode_nxt = MODE_EXEC;
            MODE_EXEC: if (w_exec_done && e_stop)  w_mode_nxt = MODE_STOP;
            default:                               w_mode_nxt = r_mode;
        endcase
    end

    // Boot handshake pulses may arrive in either order, so each is latched until both are seen.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_ld_f <= 1'b0;
            r_ak_f <= 1'b0;
        end else if (r_mode == MODE_LOAD) begin
            if (load_done) r_ld_f <= 1'b1;
            if (aa_sent)   r_ak_f <= 1'b1;
        end
    end

    // Suppressed on the STOP transition so e_start never pulses outside EXEC.
    always_ff @(posedge clk) begin
        if (!rstn) r_e_start <= 1'b0;
        else       r_e_start <= w_exec_done && (w_mode_nxt == MODE_EXEC);
    end

    always_comb begin
        fd_update = UPD_CLR;
        de_update = UPD_CLR;
        ew_update = UPD_CLR;
        case (r_mode)
            MODE_EXEC: begin
                if (!w_exec_done) begin
                    fd_update = UPD_HOLD;
                    de_update = UPD_HOLD;
                    ew_update = UPD_HOLD;
                end else if (e_redirect) begin
                    fd_update = UPD_CLR;
                    de_update = UPD_CLR;
                    ew_update = UPD_ADV;
                end else if (d_hazard) begin
                    fd_update = UPD_HOLD;
                    de_update = UPD_CLR;
                    ew_update = UPD_ADV;
                end else begin
                    fd_update = UPD_ADV;
                    de_update = UPD_ADV;
                    ew_update = UPD_ADV;
                end
            end
            MODE_STOP: begin
                fd_update = UPD_HOLD;
                de_update = UPD_HOLD;
                ew_update = UPD_HOLD;
            end
            default: begin
                fd_update = UPD_CLR;
                de_update = UPD_CLR;
                ew_update = UPD_CLR;
            end
        endcase
    end

    assign e_start   = r_e_start;
    assign exec_done = w_exec_done;
    assign mode      = r_mode;

`ifdef PIPE_CTRL_PERF_EN
    logic [PERF_W-1:0] r_cycles, r_stalls, r_flush;
    logic              w_stall, w_flush;

    assign w_stall = w_in_exec && (!w_exec_done || (!e_redirect && d_hazard));
    assign w_flush = w_exec_done && e_redirect;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_cycles <= '0;
            r_stalls <= '0;
            r_flush  <= '0;
        end else begin
            if (w_in_exec && r_cycles != '1) r_cycles <= r_cycles + PERF_W'(1);
            if (w_stall   && r_stalls != '1) r_stalls <= r_stalls + PERF_W'(1);
            if (w_flush   && r_flush  != '1) r_flush  <= r_flush  + PERF_W'(1);
        end
    end

    assign perf_cycles = r_cycles;
    assign perf_stalls = r_stalls;
    assign perf_flush  = r_flush;
`else
    assign perf_cycles = '0;
    assign perf_stalls = '0;
    assign perf_flush  = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed boot/execute/stop sequence, then random traffic
// compared each cycle against a behavioural model of the sequencer rules.
module tb_pipe_ctrl;

    localparam int LAT_W  = 5;
    localparam int PERF_W = 32;

    logic              clk = 1'b0;
    logic              rstn;
    logic              aa_received, aa_sent, load_done, d_hazard;
    logic [LAT_W-1:0]  e_wait_time;
    logic              e_busy, e_redirect, e_stop;
    logic [1:0]        fd_update, de_update, ew_update, mode;
    logic              e_start, exec_done;
    logic [PERF_W-1:0] perf_cycles, perf_stalls, perf_flush;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    pipe_ctrl #(.LAT_W(LAT_W), .PERF_W(PERF_W)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .aa_received (aa_received),
        .aa_sent     (aa_sent),
        .load_done   (load_done),
        .d_hazard    (d_hazard),
        .e_wait_time (e_wait_time),
        .e_busy      (e_busy),
        .e_redirect  (e_redirect),
        .e_stop      (e_stop),
        .fd_update   (fd_update),
        .de_update   (de_update),
        .ew_update   (ew_update),
        .e_start     (e_start),
        .exec_done   (exec_done),
        .mode        (mode),
        .perf_cycles (perf_cycles),
        .perf_stalls (perf_stalls),
        .perf_flush  (perf_flush)
    );

    task automatic chk(input string name, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: mode 0..3, latency count, handshake seen-flags, counters.
    bit     m_valid = 0;
    int     m_mode, m_lat;
    bit     m_ld, m_ak, m_estart;
    longint m_cyc, m_stl, m_fls;

    always @(negedge clk) begin
        bit done;
        int efd, ede, eew;
        done = (m_mode == 2) && (m_lat == int'(e_wait_time)) && !e_busy;
        if (m_mode <= 1)      begin efd = 2; ede = 2; eew = 2; end
        else if (m_mode == 3) begin efd = 0; ede = 0; eew = 0; end
        else if (!done)       begin efd = 0; ede = 0; eew = 0; end
        else if (e_redirect)  begin efd = 2; ede = 2; eew = 1; end
        else if (d_hazard)    begin efd = 0; ede = 2; eew = 1; end
        else                  begin efd = 1; ede = 1; eew = 1; end
        if (m_valid) begin
            chk("m_mode",      mode,      m_mode);
            chk("m_exec_done", exec_done, done);
            chk("m_e_start",   e_start,   m_estart);
            chk("m_fd",        fd_update, efd);
            chk("m_de",        de_update, ede);
            chk("m_ew",        ew_update, eew);
`ifdef PIPE_CTRL_PERF_EN
            chk("m_perf_cycles", perf_cycles, m_cyc);
            chk("m_perf_stalls", perf_stalls, m_stl);
            chk("m_perf_flush",  perf_flush,  m_fls);
`else
            chk("m_perf_zero", perf_cycles | perf_stalls | perf_flush, 0);
`endif
        end
        if (!rstn) begin
            m_valid = 1; m_mode = 0; m_lat = 0; m_ld = 0; m_ak = 0; m_estart = 0;
            m_cyc = 0; m_stl = 0; m_fls = 0;
        end else begin
            if (m_mode == 2) begin
                m_cyc++;
                if (!done || (!e_redirect && d_hazard)) m_stl++;
                if (done && e_redirect) m_fls++;
            end
            m_estart = done && !e_stop;
            case (m_mode)
                0: begin m_lat = 0; if (aa_received) m_mode = 1; end
                1: begin
                    m_lat = 0;
                    if (load_done) m_ld = 1;
                    if (aa_sent)   m_ak = 1;
                    if (m_ld && m_ak) m_mode = 2;
                end
                2: begin
                    if (done) m_lat = 0;
                    else if (m_lat < int'(e_wait_time)) m_lat++;
                    if (done && e_stop) m_mode = 3;
                end
                default: m_lat = 0;
            endcase
        end
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    initial begin
        int n, h;
        rstn = 1'b0; aa_received = 0; aa_sent = 0; load_done = 0; d_hazard = 0;
        e_wait_time = 5'd3; e_busy = 0; e_redirect = 0; e_stop = 0;
        repeat (3) step();
        at_neg();
        chk("rst_mode", mode, 0);
        chk("rst_fd", fd_update, 2);
        chk("rst_de", de_update, 2);
        chk("rst_ew", ew_update, 2);
        chk("rst_e_start", e_start, 0);
        chk("rst_exec_done", exec_done, 0);

        // boot: aa_received at t, aa_sent at t+2, load_done at t+5
        step(); rstn = 1'b1;
        step(); aa_received = 1;
        step(); aa_received = 0;
        step(); aa_sent = 1;
        step(); aa_sent = 0;
        step();
        step(); load_done = 1;
        at_neg();
        chk("boot_still_load", mode, 1);
        step(); load_done = 0;
        at_neg();
        chk("boot_exec", mode, 2);

        // wait_time=3: done in 4th EXEC cycle
        n = 1;
        while (!exec_done && n < 20) begin step(); n++; at_neg(); end
        chk("lat3_cycles", n, 4);
        chk("lat3_fd_adv", fd_update, 1);
        chk("lat3_ew_adv", ew_update, 1);

        step(); e_busy = 1;
        at_neg();
        chk("e_start_pulse", e_start, 1);
        chk("e_start_no_done", exec_done, 0);

        // 3 cycles to reach the wait time, then 10 parked at it while busy
        h = 0;
        for (int i = 0; i < 13; i++) begin
            if (i > 0) step();
            at_neg();
            if (!exec_done && fd_update == 2'd0 && de_update == 2'd0) h++;
        end
        chk("busy_hold_cycles", h, 13);
        step(); e_busy = 0; d_hazard = 1; e_redirect = 1;
        at_neg();
        chk("busy_release_done", exec_done, 1);
        chk("redir_fd", fd_update, 2);
        chk("redir_de", de_update, 2);
        chk("redir_ew", ew_update, 1);

        step(); e_wait_time = 5'd0; e_redirect = 0;
        at_neg();
        chk("haz_done", exec_done, 1);
        chk("haz_fd", fd_update, 0);
        chk("haz_de", de_update, 2);
        chk("haz_ew", ew_update, 1);

        step(); d_hazard = 0; e_stop = 1;
        at_neg();
        chk("stop_done", exec_done, 1);
        chk("stop_cycle_fd_adv", fd_update, 1);
        step(); e_stop = 0;
        at_neg();
        chk("stop_mode", mode, 3);
        chk("stop_fd", fd_update, 0);
        chk("stop_ew", ew_update, 0);
        chk("stop_e_start", e_start, 0);
`ifdef PIPE_CTRL_PERF_EN
        chk("perf_cycles_lit", perf_cycles, 20);
        chk("perf_stalls_lit", perf_stalls, 17);
        chk("perf_flush_lit",  perf_flush,  1);
`endif
        step(); rstn = 0;
        step(); rstn = 1;
        at_neg();
        chk("rerst_mode", mode, 0);
        chk("rerst_fd", fd_update, 2);

        // random traffic
        for (int c = 0; c < 4000; c++) begin
            step();
            rstn        = ($urandom_range(0, 149) != 0);
            aa_received = ($urandom_range(0, 7) == 0);
            aa_sent     = ($urandom_range(0, 7) == 0);
            load_done   = ($urandom_range(0, 7) == 0);
            d_hazard    = ($urandom_range(0, 2) == 0);
            e_redirect  = ($urandom_range(0, 3) == 0);
            e_stop      = ($urandom_range(0, 39) == 0);
            e_busy      = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 9) == 0) e_wait_time = 5'($urandom_range(0, 4));
        end
        step();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
